// File: rtl/mem_arbiter_pkg.sv
// Shared types for the unified-memory arbiter: FSM encoding, beat sizing and
// the icache beat address helper.
`default_nettype none

package mem_arbiter_pkg;

  localparam int BEATS  = 4;
  localparam int BEAT_W = 2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_I_BEAT = 3'd1,
    S_I_GAP  = 3'd2,
    S_D_ACC  = 3'd3,
    S_I_DONE = 3'd4,
    S_D_DONE = 3'd5
  } arb_state_e;

  function automatic logic [7:0] i_word_addr(input logic [5:0] blk, input logic [BEAT_W-1:0] beat);
    return {blk, beat};
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_arbiter_grant.sv
// mem_arb_grant: combinational grant between icache and dcache requests.
// With MEM_ARB_RR_EN the module also holds the round-robin pointer.
`default_nettype none

module mem_arb_grant (
`ifdef MEM_ARB_RR_EN
  input  logic clk_i,
  input  logic rst_ni,
  input  logic upd_i,
`endif
  input  logic i_req_i,
  input  logic d_req_i,
  output logic i_gnt_o,
  output logic d_gnt_o
);

`ifdef MEM_ARB_RR_EN
  // ptr_q == 0 favours the icache, 1 favours the dcache
  logic ptr_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= 1'b0;
    end else if (upd_i && i_req_i && d_req_i) begin
      ptr_q <= ~ptr_q;
    end
  end

  always_comb begin
    i_gnt_o = i_req_i;
    d_gnt_o = d_req_i;
    if (i_req_i && d_req_i) begin
      i_gnt_o = ~ptr_q;
      d_gnt_o = ptr_q;
    end
  end
`else
  always_comb begin
    d_gnt_o = d_req_i;
    i_gnt_o = i_req_i & ~d_req_i;
  end
`endif

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one word-wide main memory between icache refills (4 beats)
// and dcache single-word accesses. Define MEM_ARB_RR_EN for round-robin arbitration.
`default_nettype none

module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int MADDR_W   = 9,
  parameter int DATA_BASE = 256
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic               INSTR_MEM_READ,
  input  logic [5:0]         INSTR_MEM_ADDRESS,
  output logic [127:0]       INSTR_MEM_INSTR,
  output logic               INSTR_MEM_BUSYWAIT,
  input  logic               MEM_READ,
  input  logic               MEM_WRITE,
  input  logic [5:0]         MEM_ADDRESS,
  input  logic [31:0]        MEM_WRITEDATA,
  output logic [31:0]        MEM_READDATA,
  output logic               MEM_BUSYWAIT,
  output logic               MM_READ,
  output logic               MM_WRITE,
  output logic [MADDR_W-1:0] MM_ADDRESS,
  output logic [31:0]        MM_WRITEDATA,
  input  logic [31:0]        MM_READDATA,
  input  logic               MM_BUSYWAIT
);

  localparam logic [MADDR_W-1:0] DBASE = MADDR_W'(DATA_BASE);

  arb_state_e          state_q;
  logic [BEAT_W-1:0]   beat_q;
  logic [5:0]          i_blk_q;
  logic                d_wr_q;
  logic [127:0]        instr_q;
  logic [31:0]         rdata_q;
  logic                mm_rd_q;
  logic                mm_wr_q;
  logic [MADDR_W-1:0]  mm_addr_q;
  logic [31:0]         mm_wdata_q;

  logic                w_d_req;
  logic                w_i_gnt;
  logic                w_d_gnt;
  logic [BEAT_W-1:0]   w_beat_nxt;

  assign w_d_req    = MEM_READ | MEM_WRITE;
  assign w_beat_nxt = beat_q + 2'd1;

`ifdef MEM_ARB_RR_EN
  logic w_idle;
  assign w_idle = (state_q == S_IDLE);
`endif

  mem_arb_grant u_grant (
`ifdef MEM_ARB_RR_EN
    .clk_i  (CLK),
    .rst_ni (RESET_N),
    .upd_i  (w_idle),
`endif
    .i_req_i(INSTR_MEM_READ),
    .d_req_i(w_d_req),
    .i_gnt_o(w_i_gnt),
    .d_gnt_o(w_d_gnt)
  );

  // MM strobes are registered alongside the state so they drop with reset at once
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= S_IDLE;
      beat_q     <= '0;
      i_blk_q    <= '0;
      d_wr_q     <= 1'b0;
      instr_q    <= '0;
      rdata_q    <= '0;
      mm_rd_q    <= 1'b0;
      mm_wr_q    <= 1'b0;
      mm_addr_q  <= '0;
      mm_wdata_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (w_i_gnt) begin
            state_q   <= S_I_BEAT;
            beat_q    <= '0;
            i_blk_q   <= INSTR_MEM_ADDRESS;
            mm_rd_q   <= 1'b1;
            mm_addr_q <= MADDR_W'(i_word_addr(INSTR_MEM_ADDRESS, 2'd0));
          end else if (w_d_gnt) begin
            // a simultaneous read+write request is served as a write
            state_q    <= S_D_ACC;
            d_wr_q     <= MEM_WRITE;
            mm_wr_q    <= MEM_WRITE;
            mm_rd_q    <= ~MEM_WRITE;
            mm_addr_q  <= DBASE + MADDR_W'(MEM_ADDRESS);
            mm_wdata_q <= MEM_WRITEDATA;
          end
        end
        S_I_BEAT: begin
          if (!MM_BUSYWAIT) begin
            instr_q[{beat_q, 5'd0} +: 32] <= MM_READDATA;
            mm_rd_q <= 1'b0;
            state_q <= (beat_q == 2'(BEATS - 1)) ? S_I_DONE : S_I_GAP;
          end
        end
        S_I_GAP: begin
          beat_q    <= w_beat_nxt;
          mm_rd_q   <= 1'b1;
          mm_addr_q <= MADDR_W'(i_word_addr(i_blk_q, w_beat_nxt));
          state_q   <= S_I_BEAT;
        end
        S_D_ACC: begin
          if (!MM_BUSYWAIT) begin
            if (!d_wr_q) begin
              rdata_q <= MM_READDATA;
            end
            mm_rd_q <= 1'b0;
            mm_wr_q <= 1'b0;
            state_q <= S_D_DONE;
          end
        end
        S_I_DONE: state_q <= S_IDLE;
        S_D_DONE: state_q <= S_IDLE;
        default: begin
          state_q <= S_IDLE;
          mm_rd_q <= 1'b0;
          mm_wr_q <= 1'b0;
        end
      endcase
    end
  end

  assign INSTR_MEM_INSTR    = instr_q;
  assign MEM_READDATA       = rdata_q;
  assign MM_READ            = mm_rd_q;
  assign MM_WRITE           = mm_wr_q;
  assign MM_ADDRESS         = mm_addr_q;
  assign MM_WRITEDATA       = mm_wdata_q;
  // stall held through grant wait; forced low while reset is asserted
  assign INSTR_MEM_BUSYWAIT = RESET_N & INSTR_MEM_READ & (state_q != S_I_DONE);
  assign MEM_BUSYWAIT       = RESET_N & w_d_req & (state_q != S_D_DONE);

endmodule

`default_nettype wire
